uart_controller: RTL and testbench
==================================

Name: uart_controller

Overview:
- Full-duplex 8N1 UART engine behind the CPU's memory-mapped peripheral block.
- Serialises bytes written to the UART TXD register and deserialises the rx line into the RXD register.
- Maintains the 3-bit UART CON status word read by software.
- Sits between the peripheral address decoder, which supplies read/write strobes, and the board UART pins.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- BIT_CLKS, CLK_FREQ/BAUD_RATE (derived localparam; 10416 at defaults), clock cycles per bit. Must be ≥ 4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_rx  in  1  serial input from pin; asynchronous to clk.
- o_tx  out  1  serial output to pin; idles high.
- i_tx_write  in  1  one-cycle strobe: CPU store to the TXD address.
- i_tx_data  in  8  byte to transmit; sampled with i_tx_write.
- i_rxd_read  in  1  one-cycle strobe: CPU load from the RXD address.
- i_con_read  in  1  one-cycle strobe: CPU load from the CON address.
- o_uart_txd  out  8  last accepted tx byte.
- o_uart_rxd  out  8  last correctly framed rx byte.
- o_uart_con  out  3  status: [0] rx_ready, [1] tx_busy, [2] tx_done.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: o_tx=1, o_uart_txd=0, o_uart_rxd=0, o_uart_con=0. Both FSMs go to IDLE and all counters clear.
- Reset mid-frame: the frame is aborted and o_tx returns to 1 on that edge; no partial byte is reported.
- Rx input conditioning: i_rx passes through a 2-FF synchroniser. All rx decisions use the synchronised value rxs and its previous value rxs_d.

Tx FSM (states IDLE, START, DATA, STOP; per-bit counter 0..BIT_CLKS-1; bit index 0..7):
- Write acceptance: i_tx_write is accepted only when tx_busy=0.
- On acceptance: o_uart_txd<=i_tx_data; shift register is loaded; tx_busy<=1; tx_done<=0; state goes to START. o_tx=0 starting the next cycle.
- Writes while busy are ignored (no effect on o_uart_txd or status). This includes a write in the final STOP cycle.
- Bit timing: each state or bit is held exactly BIT_CLKS cycles. DATA sends LSB first. STOP drives 1.
- End of frame: at the end of STOP, tx_busy<=0, tx_done<=1, state goes to IDLE.
- Frame length: first start-bit cycle to tx_busy falling is exactly 10*BIT_CLKS cycles.
- tx_done is sticky. It clears on i_con_read or on the next accepted write.

Rx FSM (states IDLE, START, DATA, STOP):
- IDLE: a falling edge (rxs_d=1, rxs=0) enters START with the counter cleared. A line held low, such as a break, does not retrigger.
- START: at count BIT_CLKS/2-1, if rxs=0 go to DATA with the counter cleared; otherwise treat as a glitch and go to IDLE.
- DATA: sample rxs every BIT_CLKS cycles, i.e. mid-bit, LSB first. After 8 samples go to STOP.
- STOP: sample after BIT_CLKS cycles.
  - rxs=1: o_uart_rxd<=byte and rx_ready<=1 on the same edge.
  - rxs=0 (framing error): discard the byte, leave o_uart_rxd and rx_ready unchanged.
  - Either way, go to IDLE.
- Clearing rx_ready: i_rxd_read clears it.
- Simultaneous byte completion and i_rxd_read: set wins.
- Overrun (new byte while rx_ready=1): o_uart_rxd is overwritten and rx_ready stays 1.
- Rx and tx are fully independent; simultaneous activity is legal.
- Latency: rx byte visible 2 cycles (synchroniser) plus the FSM path after the stop-bit mid-point.

Decomposition:
- Shared package (uart_pkg):
  - tx/rx state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3).
  - CON bit indices (CON_RX_READY=0, CON_TX_BUSY=1, CON_TX_DONE=2).
  - Peripheral addresses: TXD=32'h40000018, RXD=32'h4000001C, CON=32'h40000020.
- One natural sub-module, uart_rx_engine: synchroniser, rx FSM, and rx_ready set/clear logic. Tx stays in the top.

Test Plan (CLK_FREQ=1600, BAUD_RATE=100 → BIT_CLKS=16):
- Tx frame: write 8'hA5 when idle → o_tx sequence 0,1,0,1,0,0,1,0,1,1, each level exactly 16 cycles. tx_busy is 1 for 160 cycles, then tx_done=1 and o_uart_txd=8'hA5.
- Tx busy write: write 8'h3C at cycle 50 of a frame → ignored; o_uart_txd unchanged, frame bits unchanged. i_con_read after the frame → tx_done=0.
- Rx frame: drive the 8'h5A frame at 16 clk/bit → rx_ready=1 and o_uart_rxd=8'h5A. An i_rxd_read pulse clears rx_ready the next cycle.
- Rx errors: 4-cycle low glitch → no byte, FSM back in IDLE. Frame with stop bit 0 → o_uart_rxd keeps its old value, rx_ready stays 0.
- Set/clear collision and overrun:
  - i_rxd_read on the completion edge → rx_ready=1.
  - Second byte 8'h11 received before a read → o_uart_rxd=8'h11.
- Reset mid-tx at cycle 70 → o_tx=1 and o_uart_con=0 the next cycle. A new write is accepted immediately afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg: shared state encodings, CON bit map and peripheral addrs   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int CON_RX_READY = 0;
  localparam int CON_TX_BUSY  = 1;
  localparam int CON_TX_DONE  = 2;

  localparam logic [31:0] UART_ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] UART_ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] UART_ADDR_CON = 32'h4000_0020;

endpackage

`default_nettype wire

// File: rtl/uart_rx_engine.sv
// +----------------------------------------------------------------------+
// | uart_rx_engine: rx synchroniser, 8N1 deframer and rx_ready flag      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int BIT_CLKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  input  logic       i_rxd_read,
  output logic       o_rx_ready,
  output logic [7:0] o_rx_data
);

  localparam int              CNT_W    = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CLKS / 2 - 1);

  logic             sync1_q;
  logic             rxs_q;
  logic             rxs_d_q;
  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             byte_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    byte_ok = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only a true high-to-low transition starts a frame, so a held break is ignored.
        if (rxs_d_q && !rxs_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = 3'd0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rxs_q) begin
            data_d  = shift_q;
            byte_ok = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing byte takes priority over a simultaneous read.
    if (byte_ok) begin
      ready_d = 1'b1;
    end else if (i_rxd_read) begin
      ready_d = 1'b0;
    end else begin
      ready_d = ready_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      rxs_d_q <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      ready_q <= 1'b0;
    end else begin
      sync1_q <= i_rx;
      rxs_q   <= sync1_q;
      rxs_d_q <= rxs_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign o_rx_ready = ready_q;
  assign o_rx_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/uart_controller.sv
// +----------------------------------------------------------------------+
// | uart_controller: memory-mapped full-duplex 8N1 UART (TXD/RXD/CON)    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_controller
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_tx,
  input  logic       i_tx_write,
  input  logic [7:0] i_tx_data,
  input  logic       i_rxd_read,
  input  logic       i_con_read,
  output logic [7:0] o_uart_txd,
  output logic [7:0] o_uart_rxd,
  output logic [2:0] o_uart_con
);

  localparam int              BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int              CNT_W    = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       txd_q, txd_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_q, tx_d;
  logic             tx_busy;
  logic             tx_accept;
  logic             tx_end;
  logic             rx_ready;

  assign tx_busy = (tx_state_q != ST_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_accept  = 1'b0;
    tx_end     = 1'b0;

    case (tx_state_q)
      ST_IDLE: begin
        if (i_tx_write) begin
          tx_accept  = 1'b1;
          txd_d      = i_tx_data;
          tx_shift_d = i_tx_data;
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_end     = 1'b1;
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase

    if (tx_end) begin
      tx_done_d = 1'b1;
    end else if (tx_accept || i_con_read) begin
      tx_done_d = 1'b0;
    end else begin
      tx_done_d = tx_done_q;
    end

    // Pin level is registered from the next state so the line changes glitch-free.
    case (tx_state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      txd_q      <= 8'd0;
      tx_done_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tx_done_q  <= tx_done_d;
      tx_q       <= tx_d;
    end
  end

  uart_rx_engine #(
    .BIT_CLKS (BIT_CLKS)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .i_rx       (i_rx),
    .i_rxd_read (i_rxd_read),
    .o_rx_ready (rx_ready),
    .o_rx_data  (o_uart_rxd)
  );

  assign o_tx                     = tx_q;
  assign o_uart_txd               = txd_q;
  assign o_uart_con[CON_RX_READY] = rx_ready;
  assign o_uart_con[CON_TX_BUSY]  = tx_busy;
  assign o_uart_con[CON_TX_DONE]  = tx_done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_controller.sv
// +----------------------------------------------------------------------+
// | tb_uart_controller: directed + random bench with a bit-level model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_controller;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_tx_write = 1'b0;
  logic [7:0] i_tx_data = 8'd0;
  logic       i_rxd_read = 1'b0;
  logic       i_con_read = 1'b0;
  logic       o_tx;
  logic [7:0] o_uart_txd;
  logic [7:0] o_uart_rxd;
  logic [2:0] o_uart_con;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_controller #(
    .CLK_FREQ  (1600),
    .BAUD_RATE (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rx       (i_rx),
    .o_tx       (o_tx),
    .i_tx_write (i_tx_write),
    .i_tx_data  (i_tx_data),
    .i_rxd_read (i_rxd_read),
    .i_con_read (i_con_read),
    .o_uart_txd (o_uart_txd),
    .o_uart_rxd (o_uart_rxd),
    .o_uart_con (o_uart_con)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: tx frame as a 10-bit word indexed by elapsed bit periods; rx as
  // mid-bit samples (BIT/2 + k*BIT after the first synchronised low cycle).
  bit         m_tx_active = 0;
  int         m_tx_cyc = 0;
  logic [9:0] m_frame = 10'h3FF;
  logic [7:0] m_txd = 8'd0;
  bit         m_done = 0;
  bit         m_rx_active = 0;
  int         m_rx_t = 0;
  logic [7:0] m_rx_bits = 8'd0;
  logic [7:0] m_rxd = 8'd0;
  bit         m_ready = 0;
  logic       m_s1 = 1'b1, m_rxs = 1'b1, m_rxs_prev = 1'b1;
  bit         m_set;
  int         m_k;

  always @(negedge clk) begin
    check("o_tx", {7'd0, o_tx}, {7'd0, m_tx_active ? m_frame[m_tx_cyc / BIT] : 1'b1});
    check("o_uart_txd", o_uart_txd, m_txd);
    check("o_uart_rxd", o_uart_rxd, m_rxd);
    check("o_uart_con", {5'd0, o_uart_con}, {5'd0, m_done, m_tx_active, m_ready});

    if (reset) begin
      m_tx_active = 0; m_tx_cyc = 0; m_txd = 8'd0; m_done = 0;
      m_rx_active = 0; m_rx_t = 0; m_rxd = 8'd0; m_ready = 0;
      m_s1 = 1'b1; m_rxs = 1'b1; m_rxs_prev = 1'b1;
    end else begin
      if (i_con_read) m_done = 0;
      if (m_tx_active) begin
        m_tx_cyc++;
        if (m_tx_cyc == 10 * BIT) begin
          m_tx_active = 0;
          m_done = 1;
        end
      end else if (i_tx_write) begin
        m_tx_active = 1;
        m_tx_cyc = 0;
        m_txd = i_tx_data;
        m_frame = {1'b1, i_tx_data, 1'b0};
        m_done = 0;
      end

      m_set = 0;
      if (m_rx_active) begin
        if (m_rx_t >= BIT / 2 && (m_rx_t - BIT / 2) % BIT == 0) begin
          m_k = (m_rx_t - BIT / 2) / BIT;
          if (m_k == 0) begin
            if (m_rxs) m_rx_active = 0;
          end else if (m_k <= 8) begin
            m_rx_bits[m_k - 1] = m_rxs;
          end else begin
            if (m_rxs) begin
              m_rxd = m_rx_bits;
              m_set = 1;
            end
            m_rx_active = 0;
          end
        end
        m_rx_t++;
      end else if (m_rxs_prev && !m_rxs) begin
        m_rx_active = 1;
        m_rx_t = 1;
      end
      if (m_set) m_ready = 1;
      else if (i_rxd_read) m_ready = 0;

      m_rxs_prev = m_rxs;
      m_rxs = m_s1;
      m_s1 = i_rx;
    end
  end

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) i_rx = 1'b0;
      else if (k == 9) i_rx = stop_bit;
      else i_rx = b[k - 1];
      repeat (BIT) cyc();
    end
    i_rx = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  logic [9:0] seq = 10'b1101001010;
  int busy_cnt;
  int rnd;

  initial begin
    repeat (3) cyc();
    check("lit_reset_tx", {7'd0, o_tx}, 8'h01);
    check("lit_reset_con", {5'd0, o_uart_con}, 8'h00);
    check("lit_reset_txd", o_uart_txd, 8'h00);
    check("lit_reset_rxd", o_uart_rxd, 8'h00);
    reset = 1'b0;

    cyc();
    i_tx_write = 1'b1; i_tx_data = 8'hA5;
    cyc();
    i_tx_write = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 170; i++) begin
      if (o_uart_con[1]) busy_cnt++;
      if (i < 160 && i % 16 == 8) check("lit_tx_bit", {7'd0, o_tx}, {7'd0, seq[i / 16]});
      if (i == 50) begin i_tx_write = 1'b1; i_tx_data = 8'h3C; end
      if (i == 51) i_tx_write = 1'b0;
      if (i == 60) check("lit_busy_write_txd", o_uart_txd, 8'hA5);
      cyc();
    end
    check("lit_busy_cycles", busy_cnt[7:0], 8'd160);
    check("lit_tx_done_con", {5'd0, o_uart_con}, 8'h04);
    check("lit_tx_txd", o_uart_txd, 8'hA5);
    i_con_read = 1'b1;
    cyc();
    i_con_read = 1'b0;
    check("lit_con_read_clear", {5'd0, o_uart_con}, 8'h00);

    rx_frame(8'h5A, 1'b1);
    repeat (4) cyc();
    check("lit_rx_byte", o_uart_rxd, 8'h5A);
    check("lit_rx_ready", {5'd0, o_uart_con}, 8'h01);
    i_rxd_read = 1'b1;
    cyc();
    i_rxd_read = 1'b0;
    check("lit_rxd_read_clear", {5'd0, o_uart_con}, 8'h00);

    i_rx = 1'b0;
    repeat (4) cyc();
    i_rx = 1'b1;
    repeat (30) cyc();
    check("lit_glitch_con", {5'd0, o_uart_con}, 8'h00);
    rx_frame(8'hC3, 1'b0);
    repeat (20) cyc();
    check("lit_frame_err_rxd", o_uart_rxd, 8'h5A);
    check("lit_frame_err_con", {5'd0, o_uart_con}, 8'h00);

    fork
      rx_frame(8'h77, 1'b1);
      begin
        repeat (154) cyc();
        i_rxd_read = 1'b1;
        cyc();
        i_rxd_read = 1'b0;
      end
    join
    check("lit_collision_ready", {5'd0, o_uart_con}, 8'h01);
    check("lit_collision_rxd", o_uart_rxd, 8'h77);
    rx_frame(8'h11, 1'b1);
    repeat (4) cyc();
    check("lit_overrun_rxd", o_uart_rxd, 8'h11);
    check("lit_overrun_con", {5'd0, o_uart_con}, 8'h01);
    i_rxd_read = 1'b1;
    cyc();
    i_rxd_read = 1'b0;

    cyc();
    i_tx_write = 1'b1; i_tx_data = 8'h96;
    cyc();
    i_tx_write = 1'b0;
    repeat (70) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("lit_reset_mid_tx", {7'd0, o_tx}, 8'h01);
    check("lit_reset_mid_con", {5'd0, o_uart_con}, 8'h00);
    i_tx_write = 1'b1; i_tx_data = 8'h4B;
    cyc();
    i_tx_write = 1'b0;
    check("lit_post_reset_con", {5'd0, o_uart_con}, 8'h02);
    check("lit_post_reset_txd", o_uart_txd, 8'h4B);
    repeat (170) cyc();

    fork
      begin
        repeat (25) begin
          repeat ($urandom_range(1, 120)) cyc();
          i_tx_write = 1'b1;
          i_tx_data = 8'($urandom);
          cyc();
          i_tx_write = 1'b0;
        end
      end
      begin
        repeat (14) begin
          repeat ($urandom_range(12, 30)) cyc();
          rnd = $urandom_range(0, 9);
          if (rnd == 0) begin
            i_rx = 1'b0;
            repeat ($urandom_range(1, 6)) cyc();
            i_rx = 1'b1;
          end else begin
            rx_frame(8'($urandom), (rnd == 1) ? 1'b0 : 1'b1);
          end
        end
      end
      begin
        repeat (2600) begin
          i_rxd_read = ($urandom_range(0, 29) == 0);
          i_con_read = ($urandom_range(0, 39) == 0);
          cyc();
        end
        i_rxd_read = 1'b0;
        i_con_read = 1'b0;
      end
    join

    repeat (200) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
